// File: rtl/fifo_rd_packer.sv
// Read-side packer: drains a show-ahead FIFO port and packs LANES bytes, little-endian, into words
// on a valid/ready stream. Define FIFO_RD_PACK_PARITY_EN to add the per-lane parity output m_par.
module fifo_rd_packer #(
  parameter int unsigned DATASIZE   = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic                      rclk,
  input  logic                      rrst_n,
  input  logic                      rempty,
  input  logic [DATASIZE-1:0]       rdata,
  output logic                      rinc,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATASIZE*LANES-1:0] m_data,
  output logic [LANES-1:0]          m_keep
`ifdef FIFO_RD_PACK_PARITY_EN
  ,
  output logic [LANES-1:0]          m_par
`endif
);

  localparam int unsigned LaneW = $clog2(LANES);
  localparam int unsigned PtrW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned WordW = DATASIZE * LANES;

  localparam logic [LaneW-1:0] LaneLast = LaneW'(LANES - 1);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(OBUF_DEPTH - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(OBUF_DEPTH);

  typedef enum logic [0:0] {StAccum, StFlushWait} state_e;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] lane_q [LANES];
  logic [DATASIZE-1:0] lane_d [LANES];
  logic [LaneW-1:0]    lane_cnt_q, lane_cnt_d;

  logic             push, push_full, pop, obuf_full;
  logic [WordW-1:0] push_data;
  logic [LANES-1:0] push_keep;

  logic [WordW-1:0] obuf_data [OBUF_DEPTH];
  logic [LANES-1:0] obuf_keep [OBUF_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  assign obuf_full = (count_q == CntFull);
  assign m_valid   = (count_q != '0);
  assign pop       = m_valid & m_ready;

  // The pop strobe looks only at local state so downstream ready never reaches the FIFO.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    lane_cnt_d = lane_cnt_q;
    push       = 1'b0;
    push_full  = 1'b0;
    rinc       = rrst_n & ~rempty & (state_q == StAccum) &
                 ~((lane_cnt_q == LaneLast) & obuf_full);
    unique case (state_q)
      StAccum: begin
        if (rinc) begin
          lane_d[lane_cnt_q] = rdata;
          if (lane_cnt_q == LaneLast) begin
            push       = 1'b1;
            push_full  = 1'b1;
            lane_cnt_d = '0;
          end else begin
            lane_cnt_d = lane_cnt_q + LaneW'(1);
          end
        end
        // Flush decision uses the count after any coincident pop.
        if (flush && (lane_cnt_d != '0)) begin
          state_d = StFlushWait;
        end
      end
      StFlushWait: begin
        if (!obuf_full) begin
          push       = 1'b1;
          lane_cnt_d = '0;
          state_d    = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push_keep[i] = push_full | (LaneW'(i) < lane_cnt_q);
      push_data[i*DATASIZE +: DATASIZE] = push_keep[i] ? lane_d[i] : '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= StAccum;
      lane_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Lane and buffer storage need no reset: stale contents are masked by keep or by m_valid.
  always_ff @(posedge rclk) begin
    lane_q <= lane_d;
    if (push) begin
      obuf_data[wr_ptr_q] <= push_data;
      obuf_keep[wr_ptr_q] <= push_keep;
    end
  end

  assign m_data = m_valid ? obuf_data[rd_ptr_q] : '0;
  assign m_keep = m_valid ? obuf_keep[rd_ptr_q] : '0;

`ifdef FIFO_RD_PACK_PARITY_EN
  logic [LANES-1:0] push_par;
  logic [LANES-1:0] obuf_par [OBUF_DEPTH];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push_par[i] = push_keep[i] & (^lane_d[i]);
    end
  end

  always_ff @(posedge rclk) begin
    if (push) begin
      obuf_par[wr_ptr_q] <= push_par;
    end
  end

  assign m_par = m_valid ? obuf_par[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios then random traffic, checked against a queue model.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int D  = 2;

  logic              rclk = 1'b0;
  logic              rrst_n, rempty, rinc, flush, m_valid, m_ready;
  logic [DW-1:0]     rdata;
  logic [DW*L-1:0]   m_data;
  logic [L-1:0]      m_keep;
`ifdef FIFO_RD_PACK_PARITY_EN
  logic [L-1:0]      m_par;
`endif

  fifo_rd_packer #(
    .DATASIZE  (DW),
    .LANES     (L),
    .OBUF_DEPTH(D)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .flush  (flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep)
`ifdef FIFO_RD_PACK_PARITY_EN
    ,
    .m_par  (m_par)
`endif
  );

  always #5 rclk = ~rclk;

  int vectors = 0;
  int miscompares = 0;

  // Model: source FIFO contents, bytes gathered so far, and the words awaiting the consumer.
  byte unsigned    src[$];
  byte unsigned    acc[$];
  logic [DW*L-1:0] oq_data[$];
  logic [L-1:0]    oq_keep[$];
  logic [L-1:0]    oq_par[$];
  bit              fw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    logic [DW*L-1:0] d;
    logic [L-1:0]    k;
    logic [L-1:0]    p;
    d = '0;
    k = '0;
    p = '0;
    foreach (acc[i]) begin
      d[i*DW +: DW] = acc[i];
      k[i]          = 1'b1;
      p[i]          = ^acc[i];
    end
    oq_data.push_back(d);
    oq_keep.push_back(k);
    oq_par.push_back(p);
    acc.delete();
  endtask

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_rinc"}, 64'(rinc), 64'd0);
    chk({tag, "_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_data"}, 64'(m_data), 64'd0);
    chk({tag, "_keep"}, 64'(m_keep), 64'd0);
`ifdef FIFO_RD_PACK_PARITY_EN
    chk({tag, "_par"}, 64'(m_par), 64'd0);
`endif
  endtask

  // One clock: drive at the falling edge, check before the rising edge, then advance the model.
  task automatic step(input bit fl, input bit rdy, input bit gate);
    bit exp_rinc, exp_valid, full_b, fw_b;
    @(negedge rclk);
    flush   = fl;
    m_ready = rdy;
    rempty  = !(gate && src.size() > 0);
    rdata   = (src.size() > 0) ? src[0] : 8'h00;
    #1;
    exp_valid = (oq_data.size() != 0);
    full_b    = (oq_data.size() == D);
    fw_b      = fw;
    exp_rinc  = !rempty && !fw_b && !(acc.size() == L - 1 && full_b);
    chk("rinc", 64'(rinc), 64'(exp_rinc));
    chk("m_valid", 64'(m_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("m_data", 64'(m_data), 64'(oq_data[0]));
      chk("m_keep", 64'(m_keep), 64'(oq_keep[0]));
`ifdef FIFO_RD_PACK_PARITY_EN
      chk("m_par", 64'(m_par), 64'(oq_par[0]));
`endif
    end
    if (exp_valid && rdy) begin
      void'(oq_data.pop_front());
      void'(oq_keep.pop_front());
      void'(oq_par.pop_front());
    end
    if (exp_rinc) begin
      acc.push_back(src.pop_front());
      if (acc.size() == L) pack();
    end
    if (fw_b) begin
      if (!full_b) begin
        pack();
        fw = 1'b0;
      end
    end else if (fl && acc.size() != 0) begin
      fw = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    check_outputs_idle("mid_rst");
    acc.delete();
    oq_data.delete();
    oq_keep.delete();
    oq_par.delete();
    fw = 1'b0;
    rempty = 1'b1;
    flush  = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n  = 1'b0;
    rempty  = 1'b1;
    rdata   = '0;
    flush   = 1'b0;
    m_ready = 1'b0;
    fw      = 1'b0;
    #12;
    check_outputs_idle("reset");
    @(negedge rclk);
    rrst_n = 1'b1;

    // Back-to-back full word.
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (7) step(1'b0, 1'b1, 1'b1);

    // Partial word via flush, then packing restarts at lane 0.
    src = '{8'hAA, 8'hBB};
    repeat (2) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (6) step(1'b0, 1'b1, 1'b1);

    // Backpressure: two words plus three bytes absorbed, then the pop strobe stalls.
    for (int i = 0; i < 16; i++) src.push_back(8'(8'h30 + i));
    repeat (20) step(1'b0, 1'b0, 1'b1);
    chk("bp_rinc_stall", 64'(rinc), 64'd0);
    chk("bp_rempty", 64'(rempty), 64'd0);
    repeat (30) step(1'b0, 1'b1, 1'b1);

    // Flush coincident with the fourth pop, then flush with nothing pending.
    src = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);

    // Parity patterns: full word and single-byte flush.
    src = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h01};
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);

    // Reset with one buffered word and two pending bytes.
    src = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    repeat (6) step(1'b0, 1'b0, 1'b1);
    do_reset();
    src.delete();
    src = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    repeat (7) step(1'b0, 1'b1, 1'b1);

    // Random traffic with sporadic flushes, stalls and resets.
    for (int n = 0; n < 3000; n++) begin
      if (src.size() < 4 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 9)) src.push_back(8'($urandom));
      end
      if (n % 700 == 699) do_reset();
      step($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    repeat (12) step(1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
